// File: rtl/swc_pkg.sv
// Shared switch-core definitions: port/priority widths, the RTU response
// storage word and a constant log2 helper.
package swc_pkg;

    localparam int c_wrsw_num_ports  = 11;
    localparam int c_wrsw_prio_width = 3;

    typedef struct packed {
        logic [c_wrsw_num_ports-1:0]  mask;
        logic                         drop;
        logic [c_wrsw_prio_width-1:0] prio;
    } t_rtu_rsp;

    // Ceiling log2, usable in constant expressions (f_log2(1) = 0).
    function automatic int f_log2(input int x);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < x) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/swc_rsp_fifo_mem.sv
// Register array holding queued RTU responses: one synchronous write port and
// one asynchronous read port so the head entry falls through to the outputs.
module swc_rsp_fifo_mem
    import swc_pkg::*;
#(
    parameter int g_depth      = 4,
    parameter int g_addr_width = 2
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [g_addr_width-1:0] wr_addr,
    input  t_rtu_rsp                wr_data,
    input  logic [g_addr_width-1:0] rd_addr,
    output t_rtu_rsp                rd_data
);

    t_rtu_rsp mem [g_depth];

    // Storage is deliberately not reset; validity is tracked by the owner's count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/swc_rtu_rsp_queue.sv
// In-order buffer between the RTU and the swc_core response port. Empty masks
// are turned into drops on write, and popped drops are counted (saturating).
module swc_rtu_rsp_queue
    import swc_pkg::*;
#(
    parameter int g_num_ports  = c_wrsw_num_ports,
    parameter int g_prio_width = c_wrsw_prio_width,
    parameter int g_depth      = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      rtu_rsp_valid_i,
    output logic                      rtu_rsp_ack_o,
    input  logic [g_num_ports-1:0]    rtu_dst_port_mask_i,
    input  logic                      rtu_drop_i,
    input  logic [g_prio_width-1:0]   rtu_prio_i,

    output logic                      rsp_valid_o,
    input  logic                      rsp_ack_i,
    output logic [g_num_ports-1:0]    rsp_dst_port_mask_o,
    output logic                      rsp_drop_o,
    output logic [g_prio_width-1:0]   rsp_prio_o,

    input  logic                      flush_i,
    output logic [f_log2(g_depth):0]  count_o,
    output logic [15:0]               drop_cnt_o
);

    localparam int c_ptr_w = f_log2(g_depth);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_count = c_cnt_w'(g_depth);

    logic [c_ptr_w-1:0] rd_ptr;
    logic [c_ptr_w-1:0] wr_ptr;
    logic [c_cnt_w-1:0] count;
    logic [15:0]        drop_cnt;

    logic     full;
    logic     push;
    logic     pop;
    t_rtu_rsp wr_word;
    t_rtu_rsp head;

    // Push ignores pops in the same cycle so the RTU-side ack never depends on rsp_ack_i.
    assign full          = (count == c_full_count);
    assign push          = rtu_rsp_valid_i & ~full & ~flush_i & ~rst_i;
    assign pop           = rsp_valid_o & rsp_ack_i & ~flush_i;
    assign rtu_rsp_ack_o = push;
    assign rsp_valid_o   = (count != '0);

    always_comb begin
        wr_word      = '0;
        wr_word.mask = rtu_dst_port_mask_i;
        wr_word.drop = rtu_drop_i | (rtu_dst_port_mask_i == '0);
        wr_word.prio = rtu_prio_i;
    end

    swc_rsp_fifo_mem #(
        .g_depth      (g_depth),
        .g_addr_width (c_ptr_w)
    ) u_mem (
        .clk     (clk_i),
        .we      (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_word),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Statistics survive a flush; only reset clears them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt <= '0;
        end else if (pop && head.drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign rsp_dst_port_mask_o = head.mask;
    assign rsp_drop_o          = head.drop;
    assign rsp_prio_o          = head.prio;
    assign count_o             = count;
    assign drop_cnt_o          = drop_cnt;

endmodule

// File: tb/tb_swc_rtu_rsp_queue.sv
// Scoreboard bench for swc_rtu_rsp_queue: accepted pushes are modelled in a
// queue and compared against the head entry whenever the DUT pops.
module tb_swc_rtu_rsp_queue;
    import swc_pkg::*;

    localparam int c_depth = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        rtu_rsp_valid_i = 1'b0;
    logic        rtu_rsp_ack_o;
    logic [10:0] rtu_dst_port_mask_i = '0;
    logic        rtu_drop_i = 1'b0;
    logic [2:0]  rtu_prio_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ack_i = 1'b0;
    logic [10:0] rsp_dst_port_mask_o;
    logic        rsp_drop_o;
    logic [2:0]  rsp_prio_o;
    logic        flush_i = 1'b0;
    logic [2:0]  count_o;
    logic [15:0] drop_cnt_o;

    int       test_count = 0;
    int       fail_count = 0;
    t_rtu_rsp sb[$];
    int       drop_model = 0;

    swc_rtu_rsp_queue #(
        .g_num_ports  (11),
        .g_prio_width (3),
        .g_depth      (c_depth)
    ) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .rtu_rsp_valid_i     (rtu_rsp_valid_i),
        .rtu_rsp_ack_o       (rtu_rsp_ack_o),
        .rtu_dst_port_mask_i (rtu_dst_port_mask_i),
        .rtu_drop_i          (rtu_drop_i),
        .rtu_prio_i          (rtu_prio_i),
        .rsp_valid_o         (rsp_valid_o),
        .rsp_ack_i           (rsp_ack_i),
        .rsp_dst_port_mask_o (rsp_dst_port_mask_o),
        .rsp_drop_o          (rsp_drop_o),
        .rsp_prio_o          (rsp_prio_o),
        .flush_i             (flush_i),
        .count_o             (count_o),
        .drop_cnt_o          (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs mid-cycle,
    // advance the model at the edge, then check the registered outputs.
    task automatic applyStimulus(input logic valid, input logic [10:0] mask,
                                 input logic drop, input logic [2:0] prio,
                                 input logic ack, input logic flush);
        logic     exp_ack;
        t_rtu_rsp exp_head;
        t_rtu_rsp new_entry;
        rtu_rsp_valid_i     = valid;
        rtu_dst_port_mask_i = mask;
        rtu_drop_i          = drop;
        rtu_prio_i          = prio;
        rsp_ack_i           = ack;
        flush_i             = flush;
        @(negedge clk_i);
        exp_ack = valid && (sb.size() < c_depth) && !flush;
        checkOutput("rtu_rsp_ack", 32'(rtu_rsp_ack_o), 32'(exp_ack));
        checkOutput("rsp_valid", 32'(rsp_valid_o), 32'(sb.size() != 0));
        if (sb.size() != 0 && ack && !flush) begin
            exp_head = sb.pop_front();
            checkOutput("head_mask", 32'(rsp_dst_port_mask_o), 32'(exp_head.mask));
            checkOutput("head_drop", 32'(rsp_drop_o), 32'(exp_head.drop));
            checkOutput("head_prio", 32'(rsp_prio_o), 32'(exp_head.prio));
            if (exp_head.drop && drop_model < 16'hFFFF) begin
                drop_model++;
            end
        end
        if (flush) begin
            sb.delete();
        end
        if (exp_ack) begin
            new_entry.mask = mask;
            new_entry.drop = drop | (mask == 11'h000);
            new_entry.prio = prio;
            sb.push_back(new_entry);
        end
        @(posedge clk_i);
        #1;
        checkOutput("count", 32'(count_o), 32'(sb.size()));
        checkOutput("drop_cnt", 32'(drop_cnt_o), 32'(drop_model));
    endtask

    initial begin
        rtu_rsp_valid_i = 1'b1;
        #3;
        checkOutput("reset_ack", 32'(rtu_rsp_ack_o), 32'h0);
        checkOutput("reset_valid", 32'(rsp_valid_o), 32'h0);
        checkOutput("reset_count", 32'(count_o), 32'h0);
        checkOutput("reset_drop_cnt", 32'(drop_cnt_o), 32'h0);
        rtu_rsp_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Single entry round trip.
        applyStimulus(1'b1, 11'h001, 1'b0, 3'd2, 1'b0, 1'b0);
        checkOutput("single_valid", 32'(rsp_valid_o), 32'h1);
        checkOutput("single_count", 32'(count_o), 32'h1);
        applyStimulus(1'b0, 11'h000, 1'b0, 3'd0, 1'b1, 1'b0);
        checkOutput("single_empty", 32'(count_o), 32'h0);

        // Fill, refused fifth push, then pop-while-full refusing the push.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 11'(11'h010 << i), 1'b0, 3'(i), 1'b0, 1'b0);
        end
        checkOutput("full_count", 32'(count_o), 32'h4);
        applyStimulus(1'b1, 11'h7FF, 1'b0, 3'd5, 1'b0, 1'b0);
        applyStimulus(1'b1, 11'h7FF, 1'b0, 3'd5, 1'b1, 1'b0);
        checkOutput("full_pop_count", 32'(count_o), 32'h3);
        applyStimulus(1'b1, 11'h7FF, 1'b0, 3'd5, 1'b0, 1'b0);
        checkOutput("refill_count", 32'(count_o), 32'h4);
        repeat (4) applyStimulus(1'b0, 11'h000, 1'b0, 3'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 11'h000, 1'b0, 3'd0, 1'b1, 1'b0);

        // Empty mask normalised to drop, explicit drop passes through.
        applyStimulus(1'b1, 11'h000, 1'b0, 3'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 11'h400, 1'b1, 3'd6, 1'b0, 1'b0);
        applyStimulus(1'b0, 11'h000, 1'b0, 3'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 11'h000, 1'b0, 3'd0, 1'b1, 1'b0);
        checkOutput("two_drops", 32'(drop_cnt_o), 32'h2);

        // Flush with concurrent push and pop requests.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 11'h000, 1'b1, 3'(i), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 11'h0F0, 1'b0, 3'd3, 1'b1, 1'b1);
        checkOutput("flush_count", 32'(count_o), 32'h0);
        checkOutput("flush_valid", 32'(rsp_valid_o), 32'h0);
        checkOutput("flush_drop_cnt", 32'(drop_cnt_o), 32'h2);

        // Sustained push+pop of drops, long enough to saturate the counter.
        applyStimulus(1'b1, 11'h000, 1'b0, 3'd7, 1'b0, 1'b0);
        for (int i = 0; i < 65540; i++) begin
            applyStimulus(1'b1, 11'h000, 1'b0, 3'(i), 1'b1, 1'b0);
        end
        checkOutput("drop_saturated", 32'(drop_cnt_o), 32'hFFFF);
        checkOutput("stream_count", 32'(count_o), 32'h1);

        // Asynchronous reset in the middle of a cycle.
        applyStimulus(1'b1, 11'h003, 1'b0, 3'd4, 1'b0, 1'b0);
        rtu_rsp_valid_i = 1'b1;
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("async_rst_ack", 32'(rtu_rsp_ack_o), 32'h0);
        checkOutput("async_rst_valid", 32'(rsp_valid_o), 32'h0);
        checkOutput("async_rst_count", 32'(count_o), 32'h0);
        checkOutput("async_rst_drop_cnt", 32'(drop_cnt_o), 32'h0);
        sb.delete();
        drop_model = 0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        applyStimulus(1'b1, 11'h155, 1'b0, 3'd3, 1'b0, 1'b0);
        applyStimulus(1'b0, 11'h000, 1'b0, 3'd0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
